// File: rtl/apb_spi_pkg.sv
// apb_spi_pkg
//   Shared types and constants for the APB-to-SPI multi-channel master.
//   - spi_state_t : APB/transfer FSM state encoding
//   - MODE0..MODE3: SPI mode numbers, mode = {CPOL, CPHA}
//   - spi_mode()  : maps a CPOL/CPHA pair onto a mode number
package apb_spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    DONE     = 3'd4
  } spi_state_t;

  localparam int MODE0 = 0;
  localparam int MODE1 = 1;
  localparam int MODE2 = 2;
  localparam int MODE3 = 3;

  function automatic int spi_mode(input int cpol, input int cpha);
    return (cpol * 2) + cpha;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine
//   Divider, SCLK generator and tx/rx shift registers for one SPI word.
//   The APB FSM in the top tells the engine which phase it is in; the engine
//   reports divider ticks and the end of the shift phase back.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   load               : pulse on transfer acceptance, latches tx_data
//   tx_data [DATA_W]   : word to transmit (zeros for a read)
//   setup/shifting/hold: FSM is in CS_SETUP / SHIFT / CS_HOLD
//   miso               : serial data in
//   sclk, mosi         : registered SPI clock and data out
//   rx_data [DATA_W]   : received word
//   half_tick          : last cycle of a CLK_DIV-long half period
//   shift_done         : last cycle of the SHIFT phase
module spi_shift_engine
  import apb_spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              setup,
  input  logic              shifting,
  input  logic              hold,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              half_tick,
  output logic              shift_done
);

  localparam int  DIV_W = $clog2(CLK_DIV + 1);
  localparam int  HP_W  = $clog2(2 * DATA_W + 1);
  localparam int  MODE  = spi_mode(CPOL, CPHA);
  // Modes 0 and 2 sample on the leading edge, modes 1 and 3 on the trailing.
  localparam bit  SAMPLE_LEAD = (MODE == MODE0) || (MODE == MODE2);
  localparam logic IDLE_LVL = 1'(CPOL);

  logic [DIV_W-1:0]  div_cnt;
  logic [HP_W-1:0]   hp_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_next;
  logic              active;
  logic              hp_last;
  logic              lead_edge;
  logic              trail_edge;
  logic              sample_edge;
  logic              shift_edge;

  // Edge decode: the SCLK edge that starts half period k is produced at the
  // clock edge ending half period k-1 (or the setup phase for k = 0).
  // Even k is a leading edge, odd k a trailing edge; the last half period
  // sits at the idle level so no edge is produced when SHIFT ends.
  always_comb begin
    active      = setup | shifting | hold;
    half_tick   = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    hp_last     = (hp_cnt == HP_W'(2 * DATA_W - 1));
    shift_done  = shifting && half_tick && hp_last;
    lead_edge   = half_tick && (setup || (shifting && hp_cnt[0] && !hp_last));
    trail_edge  = half_tick && shifting && !hp_cnt[0];
    sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
    shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;
    tx_next     = tx_sr << 1;
  end

  assign rx_data = rx_sr;

  // Half-period divider, idle and cleared outside the three CS phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= {DIV_W{1'b0}};
    end else if (!active || half_tick) begin
      div_cnt <= {DIV_W{1'b0}};
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Half-period counter, only runs during SHIFT and stops at the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      hp_cnt <= {HP_W{1'b0}};
    end else if (!shifting) begin
      hp_cnt <= {HP_W{1'b0}};
    end else if (half_tick && !hp_last) begin
      hp_cnt <= hp_cnt + HP_W'(1);
    end else begin
      hp_cnt <= hp_cnt;
    end
  end

  // SCLK, MOSI and the shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk  <= IDLE_LVL;
      mosi  <= 1'b0;
      tx_sr <= {DATA_W{1'b0}};
      rx_sr <= {DATA_W{1'b0}};
    end else if (load) begin
      sclk  <= IDLE_LVL;
      tx_sr <= tx_data;
      rx_sr <= {DATA_W{1'b0}};
      // With leading-edge sampling the MSB must already be on MOSI.
      mosi  <= SAMPLE_LEAD ? tx_data[DATA_W-1] : 1'b0;
    end else begin
      if (lead_edge || trail_edge) begin
        sclk <= ~sclk;
      end
      if (sample_edge) begin
        rx_sr <= (rx_sr << 1) | DATA_W'(miso);
      end
      if (shift_edge) begin
        tx_sr <= tx_next;
        // Leading-edge samplers already presented the MSB, so move to the
        // next bit; trailing-edge samplers present the current MSB now.
        mosi  <= SAMPLE_LEAD ? tx_next[DATA_W-1] : tx_sr[DATA_W-1];
      end
      if (shift_done) begin
        mosi <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_spi_master_mc.sv
// apb_spi_master_mc
//   APB slave that turns each access into one full-duplex SPI word on one of
//   NUM_SLAVES chip-selects. Slave index = PADDR >> SPAN_LOG2; indices past
//   NUM_SLAVES complete with PSLVERR after one wait state and no SPI activity.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE       : APB control
//   PADDR [ADDR_W]              : APB address
//   PWDATA [APB_DW]             : APB write data (low DATA_W bits sent)
//   PRDATA [APB_DW]             : read data, zero-extended received word
//   PREADY, PSLVERR             : registered one-cycle completion / error
//   SCLK, MOSI, MISO            : SPI bus
//   CS_N [NUM_SLAVES]           : active-low chip-selects
module apb_spi_master_mc
  import apb_spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int APB_DW     = 32,
  parameter int ADDR_W     = 16,
  parameter int NUM_SLAVES = 3,
  parameter int SPAN_LOG2  = 6,
  parameter int CLK_DIV    = 2,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [APB_DW-1:0]     PWDATA,
  output logic [APB_DW-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [NUM_SLAVES-1:0] CS_N
);

  spi_state_t            state;
  logic                  wr;
  logic                  access;
  logic                  in_range;
  logic                  load;
  logic                  setup;
  logic                  shifting;
  logic                  hold;
  logic                  half_tick;
  logic                  shift_done;
  logic [ADDR_W-1:0]     idx;
  logic [NUM_SLAVES-1:0] cs_sel;
  logic [DATA_W-1:0]     tx_data;
  logic [DATA_W-1:0]     rx_data;
  logic                  unused_pwdata;

  // Only the low DATA_W bits of PWDATA are transmitted.
  assign unused_pwdata = ^PWDATA;

  // Address decode, acceptance and phase strobes for the engine.
  always_comb begin
    access   = PSEL & PENABLE;
    idx      = PADDR >> SPAN_LOG2;
    in_range = (idx < ADDR_W'(NUM_SLAVES));
    cs_sel   = NUM_SLAVES'(1'b1) << idx;
    load     = (state == IDLE) && access && in_range;
    setup    = (state == CS_SETUP);
    shifting = (state == SHIFT);
    hold     = (state == CS_HOLD);
    // A read shifts out zeros.
    if (PWRITE) begin
      tx_data = PWDATA[DATA_W-1:0];
    end else begin
      tx_data = {DATA_W{1'b0}};
    end
  end

  spi_shift_engine #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL),
    .CPHA    (CPHA)
  ) u_engine (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .tx_data    (tx_data),
    .setup      (setup),
    .shifting   (shifting),
    .hold       (hold),
    .miso       (MISO),
    .sclk       (SCLK),
    .mosi       (MOSI),
    .rx_data    (rx_data),
    .half_tick  (half_tick),
    .shift_done (shift_done)
  );

  // APB FSM with registered CS_N, PREADY, PSLVERR and PRDATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr      <= 1'b0;
      CS_N    <= {NUM_SLAVES{1'b1}};
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= {APB_DW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= {APB_DW{1'b0}};
          if (access) begin
            wr <= PWRITE;
            if (in_range) begin
              state <= CS_SETUP;
              CS_N  <= ~cs_sel;
            end else begin
              // Unmapped slave: answer in the next cycle, bus untouched.
              state   <= DONE;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
            end
          end
        end
        CS_SETUP: begin
          if (half_tick) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_done) begin
            state <= CS_HOLD;
          end
        end
        CS_HOLD: begin
          if (half_tick) begin
            state   <= DONE;
            CS_N    <= {NUM_SLAVES{1'b1}};
            PREADY  <= 1'b1;
            PSLVERR <= 1'b0;
            PRDATA  <= wr ? {APB_DW{1'b0}} : APB_DW'(rx_data);
          end
        end
        DONE: begin
          state   <= IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= {APB_DW{1'b0}};
        end
        default: begin
          state   <= IDLE;
          CS_N    <= {NUM_SLAVES{1'b1}};
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= {APB_DW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_spi_master_mc.sv
// Bench for apb_spi_master_mc: a mode-0 and a mode-3 instance share one APB
// master; behavioural SPI slaves answer on MISO and record MOSI. Stimulus
// pushes expected results into a queue; a monitor pops on every PREADY.
module tb_apb_spi_master_mc;

  localparam int DW = 8;
  localparam int CD = 2;
  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  int          dsel;
  logic        psel0, psel1;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic        sclk0, sclk1, mosi0, mosi1, miso0, miso1;
  logic [2:0]  cs_n0, cs_n1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign psel0 = psel && (dsel == 0);
  assign psel1 = psel && (dsel == 1);

  apb_spi_master_mc #(.DATA_W(DW), .APB_DW(32), .ADDR_W(16), .NUM_SLAVES(NS),
                      .SPAN_LOG2(6), .CLK_DIV(CD), .CPOL(0), .CPHA(0)) dut0 (
    .clk(clk), .reset(reset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0), .CS_N(cs_n0));

  apb_spi_master_mc #(.DATA_W(DW), .APB_DW(32), .ADDR_W(16), .NUM_SLAVES(NS),
                      .SPAN_LOG2(6), .CLK_DIV(CD), .CPOL(1), .CPHA(1)) dut1 (
    .clk(clk), .reset(reset), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1), .CS_N(cs_n1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SPI slave models ----------------
  logic [7:0] resp0, resp1, sh0, sh1, cap0, cap1;

  // Mode 0 slave: MSB out when selected, next bit on falling SCLK, capture on rising.
  always @(cs_n0) if (cs_n0 != 3'b111) begin sh0 = resp0; miso0 = resp0[7]; cap0 = 8'h00; end
  always @(posedge sclk0) if (cs_n0 != 3'b111) cap0 = {cap0[6:0], mosi0};
  always @(negedge sclk0) if (cs_n0 != 3'b111) begin sh0 = sh0 << 1; miso0 = sh0[7]; end

  // Mode 3 slave: drive on falling (leading) SCLK, capture on rising (trailing).
  always @(cs_n1) if (cs_n1 != 3'b111) begin sh1 = resp1; miso1 = 1'b0; cap1 = 8'h00; end
  always @(negedge sclk1) if (cs_n1 != 3'b111) begin miso1 = sh1[7]; sh1 = sh1 << 1; end
  always @(posedge sclk1) if (cs_n1 != 3'b111) cap1 = {cap1[6:0], mosi1};

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          sel;
    int          start;
    logic [31:0] prdata;
    logic        err;
    int          lat;
    logic [2:0]  cs;
    logic [7:0]  mosi;
    int          edges;
    int          lowcnt;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(input int sel, input logic [15:0] addr, input logic [31:0] data,
                                 input logic wr, input logic [7:0] resp, input int start);
    exp_t e;
    int   idx;
    idx      = int'(addr) / 64;
    e.sel    = sel;
    e.start  = start;
    e.err    = (idx >= NS);
    e.lat    = e.err ? 1 : CD * (2 * DW + 2) + 1;
    e.lowcnt = e.err ? 0 : CD * (2 * DW + 2);
    e.edges  = e.err ? 0 : 2 * DW;
    e.cs     = 3'b000;
    if (!e.err) e.cs[idx] = 1'b1;
    e.mosi   = (!e.err && wr) ? data[7:0] : 8'h00;
    e.prdata = (!e.err && !wr) ? {24'h000000, resp} : 32'h0;
    return e;
  endfunction

  int         lowcnt [2];
  int         edges  [2];
  logic [2:0] orcs   [2];
  logic       prev_sclk [2];
  int         hi0;
  int         had_low0;

  task automatic score(input int d);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pready: dut%0d pulsed PREADY, expected none (cycle %0d)", d, cyc);
    end else begin
      e = q.pop_front();
      check("dut_sel", 32'(d), 32'(e.sel));
      check("prdata", d ? prdata1 : prdata0, e.prdata);
      check("pslverr", 32'(d ? pslverr1 : pslverr0), 32'(e.err));
      check("latency", 32'(cyc - e.start), 32'(e.lat));
      check("cs_pattern", 32'(orcs[d]), 32'(e.cs));
      check("cs_low_cycles", 32'(lowcnt[d]), 32'(e.lowcnt));
      check("sclk_edges", 32'(edges[d]), 32'(e.edges));
      if (!e.err) check("mosi_bits", 32'(d ? cap1 : cap0), 32'(e.mosi));
    end
    lowcnt[d] = 0;
    edges[d]  = 0;
    orcs[d]   = 3'b000;
  endtask

  // Monitor: accumulates per-transfer bus activity, scores on PREADY.
  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        lowcnt[d] = 0;
        edges[d]  = 0;
        orcs[d]   = 3'b000;
      end
      prev_sclk[0] = sclk0;
      prev_sclk[1] = sclk1;
      hi0      = 0;
      had_low0 = 0;
    end else begin
      if (cs_n0 != 3'b111) begin
        if (had_low0 != 0 && hi0 > 0) check("cs_n0_gap_ge2", 32'(hi0 >= 2), 32'd1);
        hi0 = 0;
        had_low0 = 1;
        lowcnt[0]++;
        orcs[0] |= ~cs_n0;
      end else begin
        hi0++;
      end
      if (cs_n1 != 3'b111) begin
        lowcnt[1]++;
        orcs[1] |= ~cs_n1;
      end
      if (sclk0 !== prev_sclk[0]) edges[0]++;
      if (sclk1 !== prev_sclk[1]) edges[1]++;
      prev_sclk[0] = sclk0;
      prev_sclk[1] = sclk1;
      if (pready0 || pready1) score(pready1 ? 1 : 0);
    end
  end

  // ---------------- APB master ----------------
  task automatic apb_access(input int sel, input logic [15:0] addr, input logic [31:0] data,
                            input logic wr, input logic [7:0] resp, input bit expect_done);
    int n;
    if (sel == 0) resp0 = resp; else resp1 = resp;
    @(posedge clk); #1;
    dsel = sel; psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    if (expect_done) begin
      q.push_back(model(sel, addr, data, wr, resp, cyc));
      for (n = 0; n < 200; n++) begin
        @(negedge clk);
        if ((sel == 0) ? pready0 : pready1) break;
      end
      check("pready_within_bound", 32'(n < 200), 32'd1);
    end
  endtask

  task automatic apb_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    logic [31:0] dat;
    logic        w;
    int          s;
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 16'h0; pwdata = 32'h0; dsel = 0;
    miso0 = 1'b0; miso1 = 1'b0; resp0 = 8'h00; resp1 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n0", 32'(cs_n0), 32'h7);
    check("rst_sclk0", 32'(sclk0), 32'h0);
    check("rst_mosi0", 32'(mosi0), 32'h0);
    check("rst_pready0", 32'(pready0), 32'h0);
    check("rst_pslverr0", 32'(pslverr0), 32'h0);
    check("rst_prdata0", prdata0, 32'h0);
    check("rst_cs_n1", 32'(cs_n1), 32'h7);
    check("rst_sclk1_idle_high", 32'(sclk1), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Mode 0 write to slave 1, read from slave 2, unmapped read.
    apb_access(0, 16'h0045, 32'h000000A5, 1'b1, 8'h00, 1'b1); apb_idle();
    apb_access(0, 16'h0080, 32'h00000000, 1'b0, 8'h3C, 1'b1); apb_idle();
    apb_access(0, 16'h00C0, 32'h00000000, 1'b0, 8'h77, 1'b1); apb_idle();

    // Reset ten cycles into a write: no PREADY, outputs back to reset values.
    apb_access(0, 16'h0000, 32'h0000000F, 1'b1, 8'h00, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("cs_active_before_reset", 32'(cs_n0), 32'h6);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs_n0", 32'(cs_n0), 32'h7);
    check("abort_sclk0", 32'(sclk0), 32'h0);
    check("abort_pready0", 32'(pready0), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    apb_access(0, 16'h0000, 32'h0000005A, 1'b1, 8'h00, 1'b1); apb_idle();

    // Mode 3 read.
    @(negedge clk);
    check("mode3_sclk_idle_high", 32'(sclk1), 32'h1);
    apb_access(1, 16'h0010, 32'h00000000, 1'b0, 8'hC3, 1'b1); apb_idle();

    // Back-to-back writes to slave 0.
    apb_access(0, 16'h0004, 32'h00000001, 1'b1, 8'h00, 1'b1);
    apb_access(0, 16'h0008, 32'h000000FF, 1'b1, 8'h00, 1'b1);
    apb_idle();

    // Randomised traffic on both instances.
    for (int i = 0; i < 40; i++) begin
      s   = int'($urandom_range(0, 1));
      a   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      dat = $urandom;
      w   = 1'($urandom_range(0, 1));
      apb_access(s, a, dat, w, 8'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) apb_idle();
    end
    apb_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
